// File: rtl/axi_read_arbiter_if.sv
// AXI4 read-path bundle shared by the arbiter and its environment.
// Upstream (s_*) signals are packed per master, downstream (m_*) per slave.
interface axi_read_arbiter_if #(
  parameter int MASTER_NUM = 2,
  parameter int SLAVE_NUM  = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  // upstream AR
  logic [MASTER_NUM-1:0]            s_arvalid;
  logic [MASTER_NUM-1:0]            s_arready;
  logic [MASTER_NUM*ADDR_WIDTH-1:0] s_araddr;
  logic [MASTER_NUM*8-1:0]          s_arlen;
  logic [MASTER_NUM*ID_WIDTH-1:0]   s_arid;
  // upstream R
  logic [MASTER_NUM-1:0]            s_rvalid;
  logic [MASTER_NUM-1:0]            s_rready;
  logic [DATA_WIDTH-1:0]            s_rdata;
  logic [1:0]                       s_rresp;
  logic                             s_rlast;
  logic [ID_WIDTH-1:0]              s_rid;
  // downstream AR
  logic [SLAVE_NUM-1:0]             m_arvalid;
  logic [SLAVE_NUM-1:0]             m_arready;
  logic [ADDR_WIDTH-1:0]            m_araddr;
  logic [7:0]                       m_arlen;
  logic [ID_WIDTH-1:0]              m_arid;
  // downstream R
  logic [SLAVE_NUM-1:0]             m_rvalid;
  logic [SLAVE_NUM-1:0]             m_rready;
  logic [SLAVE_NUM*DATA_WIDTH-1:0]  m_rdata;
  logic [SLAVE_NUM*2-1:0]           m_rresp;
  logic [SLAVE_NUM-1:0]             m_rlast;
  logic [SLAVE_NUM*ID_WIDTH-1:0]    m_rid;

  // Arbiter view: masters the downstream slaves, serves the upstream masters.
  modport master (
    input  s_arvalid, s_araddr, s_arlen, s_arid, s_rready,
           m_arready, m_rvalid, m_rdata, m_rresp, m_rlast, m_rid,
    output s_arready, s_rvalid, s_rdata, s_rresp, s_rlast, s_rid,
           m_arvalid, m_araddr, m_arlen, m_arid, m_rready
  );

  // Environment view: the requesting masters and responding slaves.
  modport slave (
    output s_arvalid, s_araddr, s_arlen, s_arid, s_rready,
           m_arready, m_rvalid, m_rdata, m_rresp, m_rlast, m_rid,
    input  s_arready, s_rvalid, s_rdata, s_rresp, s_rlast, s_rid,
           m_arvalid, m_araddr, m_arlen, m_arid, m_rready
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// AXI4 read arbiter: round-robin over MASTER_NUM masters, one transaction in
// flight, address decoded to SLAVE_NUM slaves, DECERR burst for unmapped hits.

// Address map: the top address nibble selects the slave (nibble j -> slave j).
// Nibbles >= SLAVE_NUM hit nothing and produce an all-zero select.
module axi_read_addr_decoder #(
  parameter int SLAVE_NUM = 3
) (
  input  logic [3:0]           region,
  output logic [SLAVE_NUM-1:0] sel
);
  // one-hot compare of the region nibble against each slave index
  always_comb begin
    sel = '0;
    for (int unsigned j = 0; j < SLAVE_NUM; j++) begin
      if (region == 4'(j)) sel[j] = 1'b1;
    end
  end
endmodule

module axi_read_arbiter #(
  parameter int MASTER_NUM = 2,
  parameter int SLAVE_NUM  = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input logic                ACLK,
  input logic                ARESET,
  axi_read_arbiter_if.master bus
);
  localparam int GW = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;

  state_t                state;
  logic [GW-1:0]         rr_ptr;
  logic [GW-1:0]         grant;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [SLAVE_NUM-1:0]  sel_q;
  logic [7:0]            beat_cnt;

  logic                  found;
  logic [GW-1:0]         winner;
  logic [GW:0]           cand;
  logic [GW-1:0]         next_ptr;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [7:0]            win_len;
  logic [ID_WIDTH-1:0]   win_id;
  logic [SLAVE_NUM-1:0]  win_sel;

  logic                  r_valid;
  logic                  r_last;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic [ID_WIDTH-1:0]   r_id;

  // round-robin search: first requester at or after the pointer, wrapping
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned i = 0; i < MASTER_NUM; i++) begin
      cand = {1'b0, rr_ptr} + (GW+1)'(i);
      if (cand >= (GW+1)'(MASTER_NUM)) cand = cand - (GW+1)'(MASTER_NUM);
      if (!found && bus.s_arvalid[cand[GW-1:0]]) begin
        found  = 1'b1;
        winner = cand[GW-1:0];
      end
    end
  end

  assign next_ptr = (int'(winner) == MASTER_NUM - 1) ? '0 : winner + 1'b1;
  assign win_addr = bus.s_araddr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
  assign win_len  = bus.s_arlen[int'(winner)*8 +: 8];
  assign win_id   = bus.s_arid[int'(winner)*ID_WIDTH +: ID_WIDTH];

  axi_read_addr_decoder #(
    .SLAVE_NUM (SLAVE_NUM)
  ) u_dec (
    .region (win_addr[ADDR_WIDTH-1 -: 4]),
    .sel    (win_sel)
  );

  // R fields of the selected slave (select is one-hot, so OR-merge is a mux)
  always_comb begin
    r_valid = 1'b0;
    r_last  = 1'b0;
    r_data  = '0;
    r_resp  = '0;
    r_id    = '0;
    for (int unsigned j = 0; j < SLAVE_NUM; j++) begin
      if (sel_q[j]) begin
        r_valid = r_valid | bus.m_rvalid[j];
        r_last  = r_last  | bus.m_rlast[j];
        r_data  = r_data  | bus.m_rdata[j*DATA_WIDTH +: DATA_WIDTH];
        r_resp  = r_resp  | bus.m_rresp[j*2 +: 2];
        r_id    = r_id    | bus.m_rid[j*ID_WIDTH +: ID_WIDTH];
      end
    end
  end

  // transaction FSM: capture in IDLE, forward AR, route or synthesize R
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      id_q     <= '0;
      sel_q    <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant    <= winner;
            addr_q   <= win_addr;
            len_q    <= win_len;
            id_q     <= win_id;
            sel_q    <= win_sel;
            beat_cnt <= '0;
            rr_ptr   <= next_ptr;
            state    <= (|win_sel) ? ADDR : ERR;
          end
        end
        ADDR: begin
          if (|(sel_q & bus.m_arready)) state <= DATA;
        end
        DATA: begin
          if (r_valid && bus.s_rready[grant] && r_last) state <= IDLE;
        end
        ERR: begin
          if (bus.s_rready[grant]) begin
            if (beat_cnt == len_q) begin
              beat_cnt <= '0;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m_araddr = addr_q;
  assign bus.m_arlen  = len_q;
  assign bus.m_arid   = id_q;

  // per-state handshake and routing outputs; ready is also masked by reset
  always_comb begin
    bus.s_arready = '0;
    bus.s_rvalid  = '0;
    bus.s_rdata   = '0;
    bus.s_rresp   = '0;
    bus.s_rlast   = 1'b0;
    bus.s_rid     = '0;
    bus.m_arvalid = '0;
    bus.m_rready  = '0;
    case (state)
      IDLE: begin
        if (found && !ARESET) bus.s_arready[winner] = 1'b1;
      end
      ADDR: begin
        bus.m_arvalid = sel_q;
      end
      DATA: begin
        bus.s_rvalid[grant] = r_valid;
        bus.m_rready        = sel_q & {SLAVE_NUM{bus.s_rready[grant]}};
        bus.s_rdata         = r_data;
        bus.s_rresp         = r_resp;
        bus.s_rlast         = r_last;
        bus.s_rid           = r_id;
      end
      ERR: begin
        bus.s_rvalid[grant] = 1'b1;
        bus.s_rresp         = 2'b11;
        bus.s_rlast         = (beat_cnt == len_q);
        bus.s_rid           = id_q;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: directed scenarios plus random transactions,
// checked against a transaction-level model (rr pointer, address map, beats).
module tb_axi_read_arbiter;
  localparam int MN = 2;
  localparam int SN = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  axi_read_arbiter_if #(
    .MASTER_NUM (MN), .SLAVE_NUM (SN), .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW), .ID_WIDTH (IW)
  ) bus ();

  axi_read_arbiter #(
    .MASTER_NUM (MN), .SLAVE_NUM (SN), .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW), .ID_WIDTH (IW)
  ) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus)
  );

  int tests = 0;
  int fails = 0;
  int ptr_model = 0;

  logic [AW-1:0] req_addr [MN];
  logic [7:0]    req_len  [MN];
  logic [IW-1:0] req_id   [MN];
  logic [MN-1:0] req_on;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // address map: top nibble j < SN targets slave j, anything else is unmapped
  function automatic int exp_slave(input logic [AW-1:0] a);
    int r;
    r = int'(a >> (AW - 4));
    return (r < SN) ? r : -1;
  endfunction

  function automatic logic [DW-1:0] slave_data(input int s, input logic [AW-1:0] a, input int b);
    return a ^ (32'h0101_0101 * 32'(b)) ^ (32'(s) << 20);
  endfunction

  function automatic logic [1:0] slave_resp(input int s, input int b);
    return 2'((s + b) % 3);
  endfunction

  task automatic quiet_inputs();
    bus.s_arvalid = '0;
    bus.s_araddr  = '0;
    bus.s_arlen   = '0;
    bus.s_arid    = '0;
    bus.s_rready  = '0;
    bus.m_arready = '0;
    bus.m_rvalid  = '0;
    bus.m_rdata   = '0;
    bus.m_rresp   = '0;
    bus.m_rlast   = '0;
    bus.m_rid     = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_arready"}, bus.s_arready, 0);
    check({tag, "_s_rvalid"},  bus.s_rvalid,  0);
    check({tag, "_s_rdata"},   bus.s_rdata,   0);
    check({tag, "_s_rlast"},   bus.s_rlast,   0);
    check({tag, "_s_rid"},     bus.s_rid,     0);
    check({tag, "_m_arvalid"}, bus.m_arvalid, 0);
    check({tag, "_m_araddr"},  bus.m_araddr,  0);
    check({tag, "_m_arlen"},   bus.m_arlen,   0);
    check({tag, "_m_rready"},  bus.m_rready,  0);
  endtask

  // One arbitration cycle plus, if granted, the whole AR and R phases.
  task automatic transact(input int ar_stall, input bit r_toggle, input int abort_beat,
                          output int granted);
    int w, s, len, beat, cyc;
    bit done, rv, rr;
    logic [MN-1:0] arr;
    @(negedge ACLK);
    quiet_inputs();
    bus.s_arvalid = req_on;
    for (int i = 0; i < MN; i++) begin
      bus.s_araddr[i*AW +: AW] = req_addr[i];
      bus.s_arlen[i*8 +: 8]    = req_len[i];
      bus.s_arid[i*IW +: IW]   = req_id[i];
    end
    #1;
    w = -1;
    for (int k = 0; k < MN; k++) begin
      if (w < 0 && req_on[(ptr_model + k) % MN]) w = (ptr_model + k) % MN;
    end
    arr = bus.s_arready;
    granted = -1;
    for (int k = 0; k < MN; k++) if (arr[k]) granted = k;
    if (w < 0) begin
      check("arready_no_req", arr, 0);
      return;
    end
    check("arready_grant", arr, MN'(1) << w);
    ptr_model = (w + 1) % MN;
    s   = exp_slave(req_addr[w]);
    len = int'(req_len[w]);
    @(posedge ACLK);

    if (s >= 0) begin
      done = 1'b0;
      for (cyc = 0; cyc < 64 && !done; cyc++) begin
        @(negedge ACLK);
        bus.m_arready = {SN{cyc >= ar_stall}};
        #1;
        check("m_arvalid",   bus.m_arvalid, SN'(1) << s);
        check("m_araddr",    bus.m_araddr,  req_addr[w]);
        check("m_arlen",     bus.m_arlen,   req_len[w]);
        check("m_arid",      bus.m_arid,    req_id[w]);
        check("arready_busy", bus.s_arready, 0);
        if (cyc >= ar_stall) done = 1'b1;
        @(posedge ACLK);
      end
      check("ar_handshake_done", done, 1);
    end

    beat = 0;
    done = 1'b0;
    for (cyc = 0; cyc < 4 * (len + 1) + 64 && !done; cyc++) begin
      @(negedge ACLK);
      bus.m_arready = '0;
      rv = (s < 0) ? 1'b1 : ($urandom_range(3) != 0);
      rr = r_toggle ? (cyc % 2 == 1) : 1'b1;
      for (int j = 0; j < SN; j++) begin
        if (j == s) begin
          bus.m_rvalid[j]            = rv;
          bus.m_rdata[j*DW +: DW]    = slave_data(s, req_addr[w], beat);
          bus.m_rresp[j*2 +: 2]      = slave_resp(s, beat);
          bus.m_rlast[j]             = (beat == len);
          bus.m_rid[j*IW +: IW]      = req_id[w];
        end else begin
          bus.m_rvalid[j]            = 1'($urandom);
          bus.m_rdata[j*DW +: DW]    = DW'($urandom);
          bus.m_rresp[j*2 +: 2]      = 2'($urandom);
          bus.m_rlast[j]             = 1'($urandom);
          bus.m_rid[j*IW +: IW]      = IW'($urandom);
        end
      end
      for (int k = 0; k < MN; k++) bus.s_rready[k] = (k == w) ? rr : 1'($urandom);
      if (abort_beat >= 0 && beat == abort_beat) begin
        ARESET = 1'b1;
        #1;
        check_all_zero("midburst_reset");
        ptr_model = 0;
        bus.s_arvalid = '0;
        #2;
        ARESET = 1'b0;
        return;
      end
      #1;
      check("s_rvalid", bus.s_rvalid, rv ? (MN'(1) << w) : MN'(0));
      check("m_rready", bus.m_rready, (s >= 0 && rr) ? (SN'(1) << s) : SN'(0));
      check("arready_in_r", bus.s_arready, 0);
      check("m_arvalid_in_r", bus.m_arvalid, 0);
      if (rv) begin
        check("s_rdata", bus.s_rdata, (s < 0) ? DW'(0) : slave_data(s, req_addr[w], beat));
        check("s_rresp", bus.s_rresp, (s < 0) ? 2'b11 : slave_resp(s, beat));
        check("s_rid",   bus.s_rid,   req_id[w]);
        check("s_rlast", bus.s_rlast, beat == len);
      end
      if (rv && rr) begin
        if (beat == len) done = 1'b1;
        beat++;
      end
      @(posedge ACLK);
    end
    check("r_burst_done", done, 1);
  endtask

  task automatic set_req(input int m, input logic [AW-1:0] a, input logic [7:0] l,
                         input logic [IW-1:0] id);
    req_addr[m] = a;
    req_len[m]  = l;
    req_id[m]   = id;
  endtask

  initial begin
    int g;
    for (int i = 0; i < MN; i++) set_req(i, '0, '0, '0);
    req_on = '0;
    quiet_inputs();
    ARESET = 1'b1;
    bus.s_arvalid = '1;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    #1;
    check_all_zero("reset");
    bus.s_arvalid = '0;
    #2;
    ARESET = 1'b0;

    // single request, master 0 -> slave 1, four beats
    set_req(0, 32'h1000_0040, 8'd3, 4'h5);
    req_on = 2'b01;
    transact(0, 1'b0, -1, g);
    check("single_grant", g, 0);

    // pointer wrap: master 1 alone, then master 0 alone, then master 1 alone
    set_req(1, 32'h2000_0100, 8'd2, 4'h3);
    req_on = 2'b10;
    transact(0, 1'b0, -1, g);
    check("wrap_grant_m1", g, 1);
    req_on = 2'b01;
    transact(0, 1'b0, -1, g);
    check("wrap_grant_m0", g, 0);
    req_on = 2'b10;
    transact(0, 1'b0, -1, g);
    check("wrap_grant_m1b", g, 1);

    // contention from pointer 0: grants alternate
    req_on = 2'b11;
    for (int k = 0; k < 4; k++) begin
      transact(0, 1'b0, -1, g);
      check("contention_grant", g, k % 2);
    end

    // unmapped address: DECERR burst of two beats
    set_req(0, 32'hF000_0000, 8'd1, 4'hA);
    req_on = 2'b01;
    transact(0, 1'b0, -1, g);
    check("decerr_grant", g, 0);

    // backpressure on AR and R, other master requesting throughout
    set_req(0, 32'h2000_0abc, 8'd5, 4'h7);
    set_req(1, 32'h0000_0010, 8'd1, 4'h1);
    req_on = 2'b11;
    transact(5, 1'b1, -1, g);
    transact(5, 1'b1, -1, g);

    // longest DECERR burst: 256 beats
    set_req(0, 32'h4000_0000, 8'd255, 4'hC);
    req_on = 2'b01;
    transact(0, 1'b0, -1, g);

    // reset after two beats of eight, then both request: pointer restarted at 0
    set_req(0, 32'h0000_2000, 8'd7, 4'h9);
    req_on = 2'b01;
    transact(0, 1'b0, 2, g);
    req_on = 2'b11;
    transact(0, 1'b0, -1, g);
    check("post_reset_grant", g, 0);

    // random traffic
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < MN; i++)
        set_req(i, {4'($urandom_range(4)), 28'($urandom)}, 8'($urandom_range(7)), IW'($urandom));
      req_on = MN'($urandom_range(3));
      transact($urandom_range(3), 1'($urandom), -1, g);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares the AXI4 read path (AR + R channels) between MASTER_NUM masters and SLAVE_NUM slaves, one transaction in flight at a time.
- Round-robin arbitration picks a master and registers its AR request. The winning address is decoded to a one-hot slave select by an internal decoder instance.
- The AR is forwarded to the selected slave and the R burst is routed back to the winning master.
- Addresses that hit no slave get a locally generated DECERR burst.

Parameters:
- MASTER_NUM, 2, number of requesting masters (≥1)
- SLAVE_NUM, 3, number of slaves; width of the decoder select
- ADDR_WIDTH, 32, ARADDR width
- DATA_WIDTH, 32, RDATA width
- ID_WIDTH, 4, ARID/RID width

Ports:
- ACLK  in  1  clock, all logic rising-edge
- ARESET  in  1  asynchronous, active-high reset
- s_arvalid  in  MASTER_NUM  per-master AR valid
- s_arready  out  MASTER_NUM  per-master AR ready
- s_araddr  in  MASTER_NUM*ADDR_WIDTH  packed, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- s_arlen  in  MASTER_NUM*8  packed burst length
- s_arid  in  MASTER_NUM*ID_WIDTH  packed ID
- s_rvalid  out  MASTER_NUM  per-master R valid
- s_rready  in  MASTER_NUM  per-master R ready
- s_rdata  out  DATA_WIDTH  shared R data, meaningful only with s_rvalid
- s_rresp  out  2  shared R response
- s_rlast  out  1  shared R last
- s_rid  out  ID_WIDTH  shared R ID
- m_arvalid  out  SLAVE_NUM  per-slave AR valid
- m_arready  in  SLAVE_NUM  per-slave AR ready
- m_araddr  out  ADDR_WIDTH  registered winning address
- m_arlen  out  8  registered winning length
- m_arid  out  ID_WIDTH  registered winning ID
- m_rvalid  in  SLAVE_NUM  per-slave R valid
- m_rready  out  SLAVE_NUM  per-slave R ready
- m_rdata  in  SLAVE_NUM*DATA_WIDTH  packed
- m_rresp  in  SLAVE_NUM*2  packed
- m_rlast  in  SLAVE_NUM  per-slave last
- m_rid  in  SLAVE_NUM*ID_WIDTH  packed

Behaviour:
- States: IDLE, ADDR, DATA, ERR.
- Reset (async, ARESET=1): state=IDLE, rr pointer=0, registers for grant/addr/len/id/select/beat counter=0, all outputs 0.
- IDLE:
  - Winner = first asserted s_arvalid at or after the pointer, wrapping modulo MASTER_NUM.
  - s_arready[winner]=1 combinationally in the same cycle; only one bit is ever high.
  - At the edge: capture addr/len/id, register the decoder select, and set pointer=(winner+1)%MASTER_NUM.
  - Next state is ADDR if select≠0, otherwise ERR. If no s_arvalid, stay in IDLE.
- ADDR:
  - m_arvalid = registered select, with m_araddr/m_arlen/m_arid stable.
  - Advance to DATA on m_arvalid&m_arready of the selected slave.
  - Minimum AR latency: master handshake in cycle N → m_arvalid in N+1.
- DATA:
  - Combinational routing: s_rvalid[winner]=m_rvalid[sel], m_rready[sel]=s_rready[winner]; s_rdata/s_rresp/s_rlast/s_rid are the selected slave's fields.
  - Non-selected slaves see m_rready=0; non-winning masters see s_rvalid=0.
  - Return to IDLE on a handshake with m_rlast=1. A new arbitration can occur in that IDLE cycle (one bubble cycle).
- ERR:
  - Generate arlen+1 beats to the winner: s_rvalid[winner]=1, rdata=0, rresp=2'b11 (DECERR), rid=captured ID.
  - s_rlast=1 on beat index==arlen; the 8-bit beat counter increments per s_rready handshake.
  - Return to IDLE after the last handshake.
- s_arready is 0 in every state except IDLE, so a second transaction is never accepted while one is in flight.
- Grant is held through stalls: s_rready low or m_arready low freezes state, no timeout.
- Simultaneous requests in IDLE: round-robin order only, no priority weighting.
- Pointer wrap: winner=MASTER_NUM-1 → pointer 0.
- arlen=255 in ERR: the counter reaches 255 without overflow, and the last beat is flagged.
- Reset mid-burst: immediate return to IDLE with all valids low; the partial burst is abandoned.

Test Plan:
- Single request: master 0 requests address mapped to slave 1, arlen=3 → m_arvalid=3'b010 one cycle after s_arready[0]; 4 R beats delivered to master 0 with rlast on the 4th; back to IDLE.
- Contention: masters 0 and 1 assert s_arvalid continuously with pointer=0 → grants alternate 0,1,0,1 across 4 transactions.
- Unmapped address: arlen=1, ID=4'hA → two beats with rresp=2'b11, rdata=0, rid=4'hA, rlast on beat 2; m_arvalid stays 0.
- Backpressure: m_arready held low 5 cycles, then s_rready toggled every other cycle → m_araddr stable throughout; no beat lost or duplicated; s_arready=0 to all masters the entire time.
- Async reset mid-DATA after beat 2 of 8 → all outputs 0 before the next clock edge; next request wins from pointer 0.
- Pointer wrap with MASTER_NUM=2: only master 1 requests, then only master 0 → both granted without stalling.
